instr_fetch_unit: RTL and testbench



---
 rtl/riscv_pkg.sv | 27 ++
 rtl/instr_field_decode.sv | 29 ++
 rtl/instr_fetch_unit.sv | 112 +++++++++++
 tb/tb_instr_fetch_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, reset PC, opcodes, fetch FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // Major opcodes consumed by control decode. OP_NOP is what an empty
    // fetch slot decodes to, so control emits ALUnop between instructions.
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_ADDI  = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_SB    = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_NOP   = 7'b0000000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_VALID = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_field_decode.sv
// Slices a 32-bit RISC-V instruction into opcode/funct/register fields, all zero when not valid.
// Latency: combinational.
// Backpressure: none.
// Ports: valid_i/instr_i in; opcode_o, funct3_o, funct7_o, rs1_o, rs2_o, rd_o out.
module instr_field_decode
    import riscv_pkg::*;
(
    input  logic        valid_i,
    input  logic [31:0] instr_i,
    output logic [6:0]  opcode_o,
    output logic [2:0]  funct3_o,
    output logic [6:0]  funct7_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o
);

    // Gating keeps downstream decode on OP_NOP whenever the slot is empty.
    logic [31:0] instr_g;
    assign instr_g = valid_i ? instr_i : 32'h0;

    assign opcode_o = instr_g[6:0];
    assign rd_o     = instr_g[11:7];
    assign funct3_o = instr_g[14:12];
    assign rs1_o    = instr_g[19:15];
    assign rs2_o    = instr_g[24:20];
    assign funct7_o = instr_g[31:25];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds PC, issues one imem request at a time, buffers the word for control decode.
// Latency: 3 cycles/instruction with zero-wait memory (FETCH, WAIT, VALID), +1 per wait cycle.
// Backpressure: address held until imem_req_ready; instruction held in VALID while stall=1.
// Ports: clk/rst_n (sync, active-high); imem_req_*/imem_rsp_* memory side; stall, PCSel,
//        alu_result from downstream; if_* presented instruction and fields; retire_count.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int               XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(riscv_pkg::RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            stall,
    input  logic            PCSel,
    input  logic [XLEN-1:0] alu_result,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4,
    output logic [31:0]     if_instr,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [31:0]     retire_count
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_plus4_q;
    logic [31:0]     instr_q;
    logic            if_valid_q;
    logic            req_valid_q;
    logic [31:0]     retire_count_q;
    logic [XLEN-1:0] next_pc_d;

    // Targets are forced word-aligned; pc+4 wraps silently at the top of the space.
    assign next_pc_d = PCSel ? (alu_result & ~XLEN'(3)) : (pc_q + XLEN'(4));

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q        <= ST_FETCH;
            pc_q           <= RESET_PC;
            pc_plus4_q     <= RESET_PC + XLEN'(4);
            instr_q        <= 32'h0;
            if_valid_q     <= 1'b0;
            req_valid_q    <= 1'b1;
            retire_count_q <= 32'h0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (imem_req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        instr_q    <= imem_rsp_data;
                        if_valid_q <= 1'b1;
                        state_q    <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (!stall) begin
                        pc_q           <= next_pc_d;
                        pc_plus4_q     <= next_pc_d + XLEN'(4);
                        // Clearing the buffer makes if_instr read 0 while empty.
                        instr_q        <= 32'h0;
                        if_valid_q     <= 1'b0;
                        req_valid_q    <= 1'b1;
                        retire_count_q <= retire_count_q + 32'd1;
                        state_q        <= ST_FETCH;
                    end
                end
                default: begin
                    state_q     <= ST_FETCH;
                    req_valid_q <= 1'b1;
                    if_valid_q  <= 1'b0;
                    instr_q     <= 32'h0;
                end
            endcase
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign if_valid       = if_valid_q;
    assign if_pc          = pc_q;
    assign if_pc_plus4    = pc_plus4_q;
    assign if_instr       = instr_q;
    assign retire_count   = retire_count_q;

    instr_field_decode u_decode (
        .valid_i  (if_valid_q),
        .instr_i  (instr_q),
        .opcode_o (opcode),
        .funct3_o (funct3),
        .funct7_o (funct7),
        .rs1_o    (rs1),
        .rs2_o    (rs2),
        .rd_o     (rd)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall;
    logic        PCSel;
    logic [31:0] alu_result;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] retire_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall          (stall),
        .PCSel          (PCSel),
        .alu_result     (alu_result),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .if_instr       (if_instr),
        .opcode         (opcode),
        .funct3         (funct3),
        .funct7         (funct7),
        .rs1            (rs1),
        .rs2            (rs2),
        .rd             (rd),
        .retire_count   (retire_count)
    );

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Zero-wait fetch of one instruction at exp_pc, then retire with the given PCSel/target.
    task automatic fetch_retire(input string tag, input logic [31:0] exp_pc,
                                input logic [31:0] word, input logic sel,
                                input logic [31:0] tgt);
        chk({tag, "_req_vld"}, {31'b0, imem_req_valid}, 32'd1);
        chk({tag, "_req_addr"}, imem_req_addr, exp_pc);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        chk({tag, "_wait_req_vld"}, {31'b0, imem_req_valid}, 32'd0);
        chk({tag, "_wait_if_vld"}, {31'b0, if_valid}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word;
        step();
        imem_rsp_valid = 1'b0;
        chk({tag, "_if_vld"}, {31'b0, if_valid}, 32'd1);
        chk({tag, "_if_instr"}, if_instr, word);
        chk({tag, "_if_pc"}, if_pc, exp_pc);
        chk({tag, "_if_pc4"}, if_pc_plus4, exp_pc + 32'd4);
        PCSel      = sel;
        alu_result = tgt;
        step();
        PCSel      = 1'b0;
        alu_result = 32'hDEAD_0000;
    endtask

    initial begin
        rst_n          = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        stall          = 1'b0;
        PCSel          = 1'b0;
        alu_result     = 32'h0;
        step();
        step();

        // Reset state
        chk("rst_req_vld", {31'b0, imem_req_valid}, 32'd1);
        chk("rst_addr", imem_req_addr, 32'h0);
        chk("rst_if_vld", {31'b0, if_valid}, 32'd0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_count", retire_count, 32'h0);
        rst_n = 1'b0;
        step();
        chk("post_rst_req_vld", {31'b0, imem_req_valid}, 32'd1);

        // 1/2: three addi NOPs at 0,4,8; the third retires to ALU target 0x41 -> 0x40
        fetch_retire("t1a", 32'h0, 32'h0000_0013, 1'b0, 32'h0);
        chk("t1a_count", retire_count, 32'd1);
        fetch_retire("t1b", 32'h4, 32'h0000_0013, 1'b0, 32'h0);
        fetch_retire("t1c", 32'h8, 32'h0000_0013, 1'b1, 32'h0000_0041);
        chk("t1_count", retire_count, 32'd3);
        chk("t2_addr", imem_req_addr, 32'h0000_0040);
        chk("t2_pc4", if_pc_plus4, 32'h0000_0044);
        chk("t2_opcode_empty", {25'b0, opcode}, 32'h0);

        // 3: addi x1,x0,10 at 0x40 held by stall for 5 cycles
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h00A0_0093;
        stall          = 1'b1;
        step();
        imem_rsp_valid = 1'b0;
        chk("t3_opcode", {25'b0, opcode}, 32'h13);
        chk("t3_rd", {27'b0, rd}, 32'd1);
        chk("t3_rs2", {27'b0, rs2}, 32'd10);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_stall_instr", if_instr, 32'h00A0_0093);
            chk("t3_stall_pc", if_pc, 32'h40);
            chk("t3_stall_count", retire_count, 32'd3);
            chk("t3_stall_req", {31'b0, imem_req_valid}, 32'd0);
        end
        stall = 1'b0;
        step();
        chk("t3_count", retire_count, 32'd4);
        chk("t3_addr", imem_req_addr, 32'h44);

        // 4: req_ready low 2 cycles, response 3 cycles late, then a second rsp that must be ignored
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t4_hold_vld", {31'b0, imem_req_valid}, 32'd1);
            chk("t4_hold_addr", imem_req_addr, 32'h44);
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_late_if_vld", {31'b0, if_valid}, 32'd0);
            chk("t4_late_req", {31'b0, imem_req_valid}, 32'd0);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h40B5_0533;
        stall          = 1'b1;
        step();
        chk("t4_if_vld", {31'b0, if_valid}, 32'd1);
        chk("t4_funct7", {25'b0, funct7}, 32'h20);
        chk("t4_rs1", {27'b0, rs1}, 32'd10);
        chk("t4_rs2", {27'b0, rs2}, 32'd11);
        chk("t4_rd", {27'b0, rd}, 32'd10);
        chk("t4_opcode", {25'b0, opcode}, 32'h33);
        imem_rsp_data = 32'hFFFF_FFFF;
        step();
        chk("t4_no_recapture", if_instr, 32'h40B5_0533);
        imem_rsp_valid = 1'b0;
        stall          = 1'b0;
        step();
        chk("t4_count", retire_count, 32'd5);
        chk("t4_addr", imem_req_addr, 32'h48);

        // 5: jump to 0x20, reset while waiting on the response
        fetch_retire("t5pre", 32'h48, 32'h0000_0013, 1'b1, 32'h0000_0020);
        chk("t5_addr20", imem_req_addr, 32'h20);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
        chk("t5_req_vld", {31'b0, imem_req_valid}, 32'd1);
        chk("t5_addr", imem_req_addr, 32'h0);
        chk("t5_if_vld", {31'b0, if_valid}, 32'd0);
        chk("t5_opcode", {25'b0, opcode}, 32'h0);
        chk("t5_count", retire_count, 32'h0);

        // 6: spurious rsp in FETCH, then wrap from 0xFFFFFFFC
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        imem_rsp_valid = 1'b0;
        chk("t6_spur_req_vld", {31'b0, imem_req_valid}, 32'd1);
        chk("t6_spur_if_vld", {31'b0, if_valid}, 32'd0);
        chk("t6_spur_instr", if_instr, 32'h0);
        fetch_retire("t6a", 32'h0, 32'h0000_0013, 1'b1, 32'hFFFF_FFFF);
        chk("t6_top_addr", imem_req_addr, 32'hFFFF_FFFC);
        chk("t6_top_pc4", if_pc_plus4, 32'h0);
        fetch_retire("t6b", 32'hFFFF_FFFC, 32'h0000_0013, 1'b0, 32'h0);
        chk("t6_wrap_addr", imem_req_addr, 32'h0);
        chk("t6_count", retire_count, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
